rvfi_retire_comparator: RTL and testbench
=========================================

RVFI_RETIRE_COMPARATOR -- requirements
Module: rvfi_retire_comparator

Interface
REQ-001 Parameter DEPTH, default 4, DUT-retirement FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 16, max cycles FIFO may be non-empty without a ref_valid_i.
REQ-003 Parameter STOP_ON_MISMATCH, default 1, freeze comparison after first mismatch.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 dut_valid_i / ref_valid_i  input  1  DUT / reference-model retirement strobe.
REQ-007 dut_order_i / ref_order_i  input  64  retirement order.
REQ-008 dut_insn_i / ref_insn_i  input  32  instruction word.
REQ-009 dut_pc_rdata_i / ref_pc_rdata_i  input  32  PC of retired instruction.
REQ-010 dut_pc_wdata_i / ref_pc_wdata_i  input  32  next PC.
REQ-011 dut_rd1_addr_i / ref_rd1_addr_i  input  5  destination register.
REQ-012 dut_rd1_wdata_i / ref_rd1_wdata_i  input  32  destination write data.
REQ-013 dut_trap_i / ref_trap_i, dut_intr_i / ref_intr_i  input  1 each  trap / interrupt flags.
REQ-014 mismatch_o  output  1  one-cycle pulse per failing comparison.
REQ-015 mismatch_fields_o  output  8  field mask of last failing comparison: [0]order [1]insn [2]pc_rdata [3]pc_wdata [4]rd1_addr [5]rd1_wdata [6]trap [7]intr.
REQ-016 match_cnt_o  output  32  passing comparisons.
REQ-017 mismatch_cnt_o  output  16  failing comparisons, saturating.
REQ-018 overflow_o, underflow_o, timeout_o, stopped_o  output  1 each  sticky status flags.

Function
REQ-019 dut_valid_i SHALL push the eight DUT fields into the FIFO tail in the same cycle.
REQ-020 ref_valid_i with FIFO non-empty SHALL pop the head and compare all fields; result registered, mismatch_o/mismatch_fields_o/counters update exactly 1 cycle after ref_valid_i.
REQ-021 rd1_wdata SHALL be compared only when both rd1_addr are non-zero; x0 writes never mismatch on bit [5].
REQ-022 Push and pop in the same cycle SHALL both take effect, including when full (occupancy unchanged) and when occupancy is 1.
REQ-023 No bypass: ref_valid_i with FIFO empty SHALL set underflow_o, perform no comparison, still accept a simultaneous push.
REQ-024 dut_valid_i with FIFO full and no pop SHALL drop the entry and set overflow_o; pointers unchanged.
REQ-025 Pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-026 Timeout counter SHALL clear on pop or empty FIFO, else increment; reaching TIMEOUT SHALL set timeout_o.
REQ-027 FSM states RUN, STOPPED; RUN->STOPPED on a mismatch when STOP_ON_MISMATCH=1; STOPPED is terminal until reset.
REQ-028 In STOPPED: pushes, pops, counters, mismatch_o frozen (mismatch_o 0); mismatch_fields_o holds; stopped_o=1.
REQ-029 match_cnt_o SHALL wrap at 2^32; mismatch_cnt_o SHALL saturate at 16'hFFFF.

Reset
REQ-030 On rst_ni low: FIFO empty, pointers 0, FSM RUN, all outputs 0, timeout counter 0, asynchronously, including mid-operation; pending entries discarded.
REQ-031 First push SHALL be accepted on the first rising edge with rst_ni high.

Structure
REQ-032 Package rvfi_cmp_pkg SHALL hold the retirement-entry struct, field-index constants for mismatch_fields_o, and the FSM state enum.
REQ-033 FIFO SHALL be sub-module rvfi_cmp_fifo (push/pop/full/empty/count); comparison and FSM in the top.

Verification
REQ-034 Push order=0..3 identical to ref entries one cycle later -> match_cnt_o=4, mismatch_cnt_o=0, all flags 0.
REQ-035 ref_rd1_wdata=32'h5 vs dut 32'h4, rd1_addr=3 -> mismatch_o pulse next cycle, mismatch_fields_o=8'h20, stopped_o=1, later valids ignored.
REQ-036 rd1_addr=0 both, wdata differs -> match counted, mismatch_o stays 0.
REQ-037 5 pushes with DEPTH=4, no ref -> overflow_o=1, 4 entries retained; then 4 refs -> match_cnt_o=4; 5th ref -> underflow_o=1.
REQ-038 One push, no ref for 16 cycles -> timeout_o=1 on cycle 16; rst_ni low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/rvfi_cmp_pkg.sv
// Shared types for the RVFI retirement comparator: the retirement entry,
// field-index constants for the mismatch mask, and the FSM state enum.
package rvfi_cmp_pkg;

  localparam int FLD_ORDER     = 0;
  localparam int FLD_INSN      = 1;
  localparam int FLD_PC_RDATA  = 2;
  localparam int FLD_PC_WDATA  = 3;
  localparam int FLD_RD1_ADDR  = 4;
  localparam int FLD_RD1_WDATA = 5;
  localparam int FLD_TRAP      = 6;
  localparam int FLD_INTR      = 7;
  localparam int NUM_FIELDS    = 8;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd1_addr;
    logic [31:0] rd1_wdata;
    logic        trap;
    logic        intr;
  } retire_entry_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_STOPPED = 1'b1
  } cmp_state_e;

  // Per-field difference mask; writes to x0 carry no architectural data,
  // so their write data is only compared when both sides target a real register.
  function automatic logic [NUM_FIELDS-1:0] compare_entries(input retire_entry_t dut_e,
                                                            input retire_entry_t ref_e);
    logic [NUM_FIELDS-1:0] diff;
    diff                = '0;
    diff[FLD_ORDER]     = (dut_e.order    != ref_e.order);
    diff[FLD_INSN]      = (dut_e.insn     != ref_e.insn);
    diff[FLD_PC_RDATA]  = (dut_e.pc_rdata != ref_e.pc_rdata);
    diff[FLD_PC_WDATA]  = (dut_e.pc_wdata != ref_e.pc_wdata);
    diff[FLD_RD1_ADDR]  = (dut_e.rd1_addr != ref_e.rd1_addr);
    diff[FLD_RD1_WDATA] = (dut_e.rd1_addr != 5'd0) && (ref_e.rd1_addr != 5'd0) &&
                          (dut_e.rd1_wdata != ref_e.rd1_wdata);
    diff[FLD_TRAP]      = (dut_e.trap     != ref_e.trap);
    diff[FLD_INTR]      = (dut_e.intr     != ref_e.intr);
    return diff;
  endfunction

endpackage

// File: rtl/rvfi_cmp_fifo.sv
// Power-of-two FIFO holding DUT retirements until the reference model catches up.
// Simultaneous push and pop are both honoured, including when full.
module rvfi_cmp_fifo
  import rvfi_cmp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  retire_entry_t          wdata_i,
  input  logic                   pop_i,
  output retire_entry_t          rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  retire_entry_t    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates every read, so
  // stale contents are never observed and the array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rvfi_retire_comparator.sv
// Compares DUT retirements against a reference model in order, reporting
// per-field mismatches, pass/fail counts and sticky health flags.
module rvfi_retire_comparator
  import rvfi_cmp_pkg::*;
#(
  parameter int DEPTH            = 4,
  parameter int TIMEOUT          = 16,
  parameter bit STOP_ON_MISMATCH = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dut_valid_i,
  input  logic [63:0] dut_order_i,
  input  logic [31:0] dut_insn_i,
  input  logic [31:0] dut_pc_rdata_i,
  input  logic [31:0] dut_pc_wdata_i,
  input  logic [4:0]  dut_rd1_addr_i,
  input  logic [31:0] dut_rd1_wdata_i,
  input  logic        dut_trap_i,
  input  logic        dut_intr_i,
  input  logic        ref_valid_i,
  input  logic [63:0] ref_order_i,
  input  logic [31:0] ref_insn_i,
  input  logic [31:0] ref_pc_rdata_i,
  input  logic [31:0] ref_pc_wdata_i,
  input  logic [4:0]  ref_rd1_addr_i,
  input  logic [31:0] ref_rd1_wdata_i,
  input  logic        ref_trap_i,
  input  logic        ref_intr_i,
  output logic        mismatch_o,
  output logic [7:0]  mismatch_fields_o,
  output logic [31:0] match_cnt_o,
  output logic [15:0] mismatch_cnt_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        timeout_o,
  output logic        stopped_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  retire_entry_t    dut_entry;
  retire_entry_t    ref_entry;
  retire_entry_t    fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic             push_en;
  logic             pop_en;
  logic [NUM_FIELDS-1:0] cmp_diff;

  cmp_state_e            state_q, state_d;
  logic                  mismatch_q, mismatch_d;
  logic [NUM_FIELDS-1:0] fields_q, fields_d;
  logic [31:0]           match_cnt_q, match_cnt_d;
  logic [15:0]           mismatch_cnt_q, mismatch_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  timeout_q, timeout_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;

  assign dut_entry = '{order: dut_order_i, insn: dut_insn_i, pc_rdata: dut_pc_rdata_i,
                       pc_wdata: dut_pc_wdata_i, rd1_addr: dut_rd1_addr_i,
                       rd1_wdata: dut_rd1_wdata_i, trap: dut_trap_i, intr: dut_intr_i};
  assign ref_entry = '{order: ref_order_i, insn: ref_insn_i, pc_rdata: ref_pc_rdata_i,
                       pc_wdata: ref_pc_wdata_i, rd1_addr: ref_rd1_addr_i,
                       rd1_wdata: ref_rd1_wdata_i, trap: ref_trap_i, intr: ref_intr_i};

  rvfi_cmp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_en),
    .wdata_i (dut_entry),
    .pop_i   (pop_en),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign cmp_diff = compare_entries(fifo_head, ref_entry);

  always_comb begin
    state_d        = state_q;
    mismatch_d     = 1'b0;
    fields_d       = fields_q;
    match_cnt_d    = match_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;
    timeout_d      = timeout_q;
    tmr_d          = tmr_q;
    push_en        = 1'b0;
    pop_en         = 1'b0;

    // STOPPED freezes everything; only reset leaves it.
    if (state_q == ST_RUN) begin
      push_en = dut_valid_i;
      pop_en  = ref_valid_i && !fifo_empty;

      if (ref_valid_i && fifo_empty)              underflow_d = 1'b1;
      if (dut_valid_i && fifo_full && !pop_en)    overflow_d  = 1'b1;

      if (pop_en) begin
        if (|cmp_diff) begin
          mismatch_d = 1'b1;
          fields_d   = cmp_diff;
          if (mismatch_cnt_q != 16'hFFFF) mismatch_cnt_d = mismatch_cnt_q + 16'd1;
          if (STOP_ON_MISMATCH) state_d = ST_STOPPED;
        end else begin
          match_cnt_d = match_cnt_q + 32'd1;
        end
      end

      // Measures how long the head has waited for its reference retirement.
      if (pop_en || fifo_cnt == '0) begin
        tmr_d = '0;
      end else if (tmr_q != TMR_W'(TIMEOUT)) begin
        tmr_d = tmr_q + TMR_W'(1);
      end
      if (tmr_d == TMR_W'(TIMEOUT)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_RUN;
      mismatch_q     <= 1'b0;
      fields_q       <= '0;
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      timeout_q      <= 1'b0;
      tmr_q          <= '0;
    end else begin
      state_q        <= state_d;
      mismatch_q     <= mismatch_d;
      fields_q       <= fields_d;
      match_cnt_q    <= match_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      timeout_q      <= timeout_d;
      tmr_q          <= tmr_d;
    end
  end

  assign mismatch_o        = mismatch_q;
  assign mismatch_fields_o = fields_q;
  assign match_cnt_o       = match_cnt_q;
  assign mismatch_cnt_o    = mismatch_cnt_q;
  assign overflow_o        = overflow_q;
  assign underflow_o       = underflow_q;
  assign timeout_o         = timeout_q;
  assign stopped_o         = (state_q == ST_STOPPED);

endmodule

// File: tb/tb_rvfi_retire_comparator.sv
// Directed-vector bench for rvfi_retire_comparator with hand-computed expectations.
module tb_rvfi_retire_comparator;
  import rvfi_cmp_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dut_valid_i = 1'b0, ref_valid_i = 1'b0;
  logic [63:0] dut_order_i = '0, ref_order_i = '0;
  logic [31:0] dut_insn_i = '0, ref_insn_i = '0;
  logic [31:0] dut_pc_rdata_i = '0, ref_pc_rdata_i = '0;
  logic [31:0] dut_pc_wdata_i = '0, ref_pc_wdata_i = '0;
  logic [4:0]  dut_rd1_addr_i = '0, ref_rd1_addr_i = '0;
  logic [31:0] dut_rd1_wdata_i = '0, ref_rd1_wdata_i = '0;
  logic        dut_trap_i = 1'b0, ref_trap_i = 1'b0;
  logic        dut_intr_i = 1'b0, ref_intr_i = 1'b0;
  logic        mismatch_o;
  logic [7:0]  mismatch_fields_o;
  logic [31:0] match_cnt_o;
  logic [15:0] mismatch_cnt_o;
  logic        overflow_o, underflow_o, timeout_o, stopped_o;

  int n_checks = 0;
  int n_fail   = 0;

  rvfi_retire_comparator #(
    .DEPTH(4), .TIMEOUT(16), .STOP_ON_MISMATCH(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dut_valid_i(dut_valid_i), .dut_order_i(dut_order_i), .dut_insn_i(dut_insn_i),
    .dut_pc_rdata_i(dut_pc_rdata_i), .dut_pc_wdata_i(dut_pc_wdata_i),
    .dut_rd1_addr_i(dut_rd1_addr_i), .dut_rd1_wdata_i(dut_rd1_wdata_i),
    .dut_trap_i(dut_trap_i), .dut_intr_i(dut_intr_i),
    .ref_valid_i(ref_valid_i), .ref_order_i(ref_order_i), .ref_insn_i(ref_insn_i),
    .ref_pc_rdata_i(ref_pc_rdata_i), .ref_pc_wdata_i(ref_pc_wdata_i),
    .ref_rd1_addr_i(ref_rd1_addr_i), .ref_rd1_wdata_i(ref_rd1_wdata_i),
    .ref_trap_i(ref_trap_i), .ref_intr_i(ref_intr_i),
    .mismatch_o(mismatch_o), .mismatch_fields_o(mismatch_fields_o),
    .match_cnt_o(match_cnt_o), .mismatch_cnt_o(mismatch_cnt_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o),
    .timeout_o(timeout_o), .stopped_o(stopped_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic retire_entry_t mk(input int ord, input logic [4:0] rd,
                                       input logic [31:0] wd);
    retire_entry_t e;
    e.order     = 64'(ord);
    e.insn      = 32'h0010_0093 + 32'(ord);
    e.pc_rdata  = 32'h8000_0000 + 32'(ord * 4);
    e.pc_wdata  = 32'h8000_0004 + 32'(ord * 4);
    e.rd1_addr  = rd;
    e.rd1_wdata = wd;
    e.trap      = 1'b0;
    e.intr      = 1'b0;
    return e;
  endfunction

  task automatic set_dut(input logic v, input retire_entry_t e);
    dut_valid_i = v; dut_order_i = e.order; dut_insn_i = e.insn;
    dut_pc_rdata_i = e.pc_rdata; dut_pc_wdata_i = e.pc_wdata;
    dut_rd1_addr_i = e.rd1_addr; dut_rd1_wdata_i = e.rd1_wdata;
    dut_trap_i = e.trap; dut_intr_i = e.intr;
  endtask

  task automatic set_ref(input logic v, input retire_entry_t e);
    ref_valid_i = v; ref_order_i = e.order; ref_insn_i = e.insn;
    ref_pc_rdata_i = e.pc_rdata; ref_pc_wdata_i = e.pc_wdata;
    ref_rd1_addr_i = e.rd1_addr; ref_rd1_wdata_i = e.rd1_wdata;
    ref_trap_i = e.trap; ref_intr_i = e.intr;
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    dut_valid_i = 1'b0;
    ref_valid_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] oth;
    dut_valid_i = 1'b0; ref_valid_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) tick();
    oth = {mismatch_o, mismatch_fields_o, mismatch_cnt_o, overflow_o, underflow_o,
           timeout_o, stopped_o, 3'b000};
    n_checks++;
    if (match_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_match_cnt: got %h want 0", match_cnt_o);
    end
    n_checks++;
    if (oth !== 32'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", oth);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_match_stream();
    do_reset();
    set_dut(1'b1, mk(0, 5'd1, 32'h0));
    tick();
    n_checks++;
    if (match_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL stream_push_only: match_cnt got %0d want 0", match_cnt_o);
    end
    for (int i = 1; i <= 4; i++) begin
      set_dut(i < 4, mk(i, 5'(i + 1), 32'h100 * i));
      set_ref(1'b1, mk(i - 1, 5'(i), 32'h100 * (i - 1)));
      tick();
      n_checks++;
      if (match_cnt_o !== 32'(i) || mismatch_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_step%0d: match_cnt=%0d mismatch=%b want %0d/0",
                 i, match_cnt_o, mismatch_o, i);
      end
    end
    set_ref(1'b0, mk(0, 5'd0, 32'h0));
    tick();
    n_checks++;
    if ({match_cnt_o, mismatch_cnt_o, mismatch_fields_o} !== {32'd4, 16'd0, 8'h00} ||
        {overflow_o, underflow_o, timeout_o, stopped_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL stream_final: match=%0d mism=%0d fields=%h flags=%b want 4/0/00/0000",
               match_cnt_o, mismatch_cnt_o, mismatch_fields_o,
               {overflow_o, underflow_o, timeout_o, stopped_o});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_dut(1'b1, mk(i, 5'd2, 32'(i)));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      set_dut(1'b1, mk(4 + i, 5'd2, 32'(4 + i)));
      set_ref(1'b1, mk(i, 5'd2, 32'(i)));
      tick();
    end
    set_dut(1'b0, mk(0, 5'd0, 32'h0));
    for (int i = 2; i < 6; i++) begin
      set_ref(1'b1, mk(i, 5'd2, 32'(i)));
      tick();
    end
    set_ref(1'b0, mk(0, 5'd0, 32'h0));
    tick();
    n_checks++;
    if (match_cnt_o !== 32'd6 || mismatch_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL b2b_counts: match=%0d mism=%0d want 6/0", match_cnt_o, mismatch_cnt_o);
    end
    n_checks++;
    if ({overflow_o, underflow_o, stopped_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_flags: ovf/unf/stop=%b want 000", {overflow_o, underflow_o, stopped_o});
    end
  endtask

  task automatic test_overflow_underflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_dut(1'b1, mk(i, 5'd7, 32'hA0 + 32'(i)));
      tick();
    end
    set_dut(1'b0, mk(0, 5'd0, 32'h0));
    n_checks++;
    if ({overflow_o, underflow_o} !== 2'b10) begin
      n_fail++; $display("FAIL ovf_set: ovf/unf=%b want 10", {overflow_o, underflow_o});
    end
    for (int i = 0; i < 4; i++) begin
      set_ref(1'b1, mk(i, 5'd7, 32'hA0 + 32'(i)));
      tick();
    end
    set_ref(1'b0, mk(0, 5'd0, 32'h0));
    tick();
    n_checks++;
    if (match_cnt_o !== 32'd4 || mismatch_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL ovf_drain: match=%0d mism=%0d want 4/0", match_cnt_o, mismatch_cnt_o);
    end
    set_ref(1'b1, mk(4, 5'd7, 32'hA4));
    set_dut(1'b1, mk(9, 5'd8, 32'h99));
    tick();
    set_ref(1'b0, mk(0, 5'd0, 32'h0));
    set_dut(1'b0, mk(0, 5'd0, 32'h0));
    n_checks++;
    if (underflow_o !== 1'b1 || match_cnt_o !== 32'd4 || mismatch_o !== 1'b0) begin
      n_fail++;
      $display("FAIL unf_set: unf=%b match=%0d mism_o=%b want 1/4/0",
               underflow_o, match_cnt_o, mismatch_o);
    end
    set_ref(1'b1, mk(9, 5'd8, 32'h99));
    tick();
    set_ref(1'b0, mk(0, 5'd0, 32'h0));
    n_checks++;
    if (match_cnt_o !== 32'd5 || mismatch_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL unf_push_kept: match=%0d mism=%0d want 5/0", match_cnt_o, mismatch_cnt_o);
    end
  endtask

  task automatic test_x0_write();
    do_reset();
    set_dut(1'b1, mk(0, 5'd0, 32'h4));
    tick();
    set_dut(1'b0, mk(0, 5'd0, 32'h0));
    set_ref(1'b1, mk(0, 5'd0, 32'h5));
    tick();
    set_ref(1'b0, mk(0, 5'd0, 32'h0));
    n_checks++;
    if ({mismatch_o, stopped_o, mismatch_fields_o} !== 10'd0 || match_cnt_o !== 32'd1) begin
      n_fail++;
      $display("FAIL x0_write: mism=%b stop=%b fields=%h match=%0d want 0/0/00/1",
               mismatch_o, stopped_o, mismatch_fields_o, match_cnt_o);
    end
  endtask

  task automatic test_timeout_and_async_reset();
    do_reset();
    set_dut(1'b1, mk(7, 5'd1, 32'h7));
    tick();
    set_dut(1'b1, mk(8, 5'd1, 32'h8));
    set_ref(1'b1, mk(7, 5'd1, 32'h7));
    tick();
    set_dut(1'b0, mk(0, 5'd0, 32'h0));
    set_ref(1'b0, mk(0, 5'd0, 32'h0));
    repeat (15) tick();
    n_checks++;
    if (timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: got %b want 0 after 15 cycles", timeout_o);
    end
    tick();
    n_checks++;
    if (timeout_o !== 1'b1 || match_cnt_o !== 32'd1) begin
      n_fail++;
      $display("FAIL timeout_at_16: timeout=%b match=%0d want 1/1", timeout_o, match_cnt_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({match_cnt_o, mismatch_cnt_o, mismatch_fields_o, mismatch_o, overflow_o,
         underflow_o, timeout_o, stopped_o} !== 61'd0) begin
      n_fail++;
      $display("FAIL async_reset: match=%0d timeout=%b flags=%b want all 0",
               match_cnt_o, timeout_o, {overflow_o, underflow_o, stopped_o});
    end
    tick();
    rst_ni = 1'b1;
    set_ref(1'b1, mk(8, 5'd1, 32'h8));
    tick();
    set_ref(1'b0, mk(0, 5'd0, 32'h0));
    n_checks++;
    if (underflow_o !== 1'b1 || match_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_discards: unf=%b match=%0d want 1/0", underflow_o, match_cnt_o);
    end
  endtask

  task automatic test_rd1_mismatch_stop();
    do_reset();
    set_dut(1'b1, mk(0, 5'd3, 32'h4));
    tick();
    set_dut(1'b0, mk(0, 5'd0, 32'h0));
    set_ref(1'b1, mk(0, 5'd3, 32'h5));
    tick();
    set_ref(1'b0, mk(0, 5'd0, 32'h0));
    n_checks++;
    if ({mismatch_o, stopped_o, mismatch_fields_o} !== {1'b1, 1'b1, 8'h20} ||
        mismatch_cnt_o !== 16'd1 || match_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL rd1_mismatch: mism=%b stop=%b fields=%h mcnt=%0d match=%0d want 1/1/20/1/0",
               mismatch_o, stopped_o, mismatch_fields_o, mismatch_cnt_o, match_cnt_o);
    end
    tick();
    n_checks++;
    if (mismatch_o !== 1'b0 || mismatch_fields_o !== 8'h20) begin
      n_fail++;
      $display("FAIL rd1_pulse_width: mism=%b fields=%h want 0/20", mismatch_o, mismatch_fields_o);
    end
    for (int i = 1; i < 7; i++) begin
      set_dut(1'b1, mk(i, 5'd3, 32'(i)));
      set_ref(1'b1, mk(i, 5'd3, 32'(i + 1)));
      tick();
    end
    set_dut(1'b0, mk(0, 5'd0, 32'h0));
    set_ref(1'b0, mk(0, 5'd0, 32'h0));
    tick();
    n_checks++;
    if ({match_cnt_o, mismatch_cnt_o, mismatch_fields_o} !== {32'd0, 16'd1, 8'h20} ||
        {mismatch_o, overflow_o, underflow_o, stopped_o} !== 4'b0001) begin
      n_fail++;
      $display("FAIL stopped_frozen: match=%0d mcnt=%0d fields=%h m/o/u/s=%b want 0/1/20/0001",
               match_cnt_o, mismatch_cnt_o, mismatch_fields_o,
               {mismatch_o, overflow_o, underflow_o, stopped_o});
    end
  endtask

  task automatic test_multi_field();
    retire_entry_t e;
    retire_entry_t r;
    do_reset();
    e = mk(2, 5'd0, 32'h1);
    r = e;
    r.order    = 64'd3;
    r.pc_wdata = e.pc_wdata + 32'd8;
    r.intr     = 1'b1;
    r.rd1_wdata = 32'h2;
    set_dut(1'b1, e);
    tick();
    set_dut(1'b0, e);
    set_ref(1'b1, r);
    tick();
    set_ref(1'b0, r);
    n_checks++;
    if ({mismatch_o, mismatch_fields_o} !== {1'b1, 8'h89} || mismatch_cnt_o !== 16'd1) begin
      n_fail++;
      $display("FAIL multi_field: mism=%b fields=%h mcnt=%0d want 1/89/1",
               mismatch_o, mismatch_fields_o, mismatch_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_match_stream();
    test_back_to_back();
    test_overflow_underflow();
    test_x0_write();
    test_timeout_and_async_reset();
    test_rd1_mismatch_stop();
    test_multi_field();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
